// File: rtl/hazard_control.sv
// Pipeline sequencer for the 5-stage core: latch enables/flushes for each stage,
// load-use bubbles, branch/jump squash, halt, and saturating stall/flush counters.
module hazard_control #(
    parameter int CNT_W            = 32,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dreq,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             ifid_jump,
    input  logic             exmem_branch,
    input  logic             memwb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN, LU_WAIT, HALTED} state_e;

    state_e           state_q, state_d;
    logic [2:0]       bub_cnt_q, bub_cnt_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c, exmem_en_c, memwb_en_c;
    logic mem_stall, lu, stall_inc, flush_inc;

    assign mem_stall = exmem_dreq & ~dhit;
    assign lu = idex_memread && (idex_rd != 5'd0) &&
                ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));

    always_comb begin
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        ifid_flush_c = 1'b0;
        idex_en_c    = 1'b0;
        idex_flush_c = 1'b0;
        exmem_en_c   = 1'b0;
        memwb_en_c   = 1'b0;
        state_d      = state_q;
        bub_cnt_d    = bub_cnt_q;
        halt_d       = halt_q;
        flush_inc    = 1'b0;

        if (state_q == HALTED) begin
            halt_d = 1'b1;
        end else if (memwb_halt) begin
            state_d = HALTED;
            halt_d  = 1'b1;
        end else if (mem_stall) begin
            // whole pipe frozen; a pending branch stays latched and is taken later
        end else if (exmem_branch) begin
            pc_en_c      = ihit;
            ifid_en_c    = 1'b1;
            ifid_flush_c = 1'b1;
            idex_en_c    = 1'b1;
            idex_flush_c = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
            state_d      = RUN;
            bub_cnt_d    = 3'd0;
            flush_inc    = 1'b1;
        end else if (state_q == LU_WAIT || lu) begin
            idex_en_c    = 1'b1;
            idex_flush_c = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
            if (state_q == LU_WAIT) begin
                bub_cnt_d = bub_cnt_q - 3'd1;
                if (bub_cnt_q == 3'd1) state_d = RUN;
            end else if (LOAD_USE_BUBBLES > 1) begin
                state_d   = LU_WAIT;
                bub_cnt_d = 3'(LOAD_USE_BUBBLES - 1);
            end
        end else begin
            // jump squash, fetch-miss bubble, or normal flow differ only in pc_en/flush
            pc_en_c      = ihit;
            ifid_en_c    = 1'b1;
            ifid_flush_c = ifid_jump | ~ihit;
            idex_en_c    = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
            flush_inc    = ifid_jump;
        end

        stall_inc   = (state_q != HALTED) && !pc_en_c;
        stall_cnt_d = (stall_inc && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (flush_inc && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            bub_cnt_q   <= 3'd0;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bub_cnt_q   <= bub_cnt_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_en      = pc_en_c & nRST;
    assign ifid_en    = ifid_en_c & nRST;
    assign ifid_flush = ifid_flush_c & nRST;
    assign idex_en    = idex_en_c & nRST;
    assign idex_flush = idex_flush_c & nRST;
    assign exmem_en   = exmem_en_c & nRST;
    assign memwb_en   = memwb_en_c & nRST;
    assign halt       = halt_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_control.sv
// Scoreboard bench for hazard_control: three instances (default, 3 bubbles, 4-bit counters)
// share stimulus; per-cycle expected output vectors are queued and popped after settling.
module tb_hazard_control;
    typedef struct packed {
        logic       ihit, dhit, exmem_dreq, idex_memread;
        logic [4:0] idex_rd, ifid_rs, ifid_rt;
        logic       ifid_uses_rt, ifid_jump, exmem_branch, memwb_halt;
    } stim_t;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halt}
    localparam logic [7:0] V_RUN    = 8'b1101_0110;
    localparam logic [7:0] V_LU     = 8'b0001_1110;
    localparam logic [7:0] V_BR     = 8'b1111_1110;
    localparam logic [7:0] V_FREEZE = 8'b0000_0000;
    localparam logic [7:0] V_HALTED = 8'b0000_0001;
    localparam logic [7:0] V_IMISS  = 8'b0111_0110;
    localparam logic [7:0] V_JUMP   = 8'b1111_0110;

    logic CLK = 1'b0, nRST = 1'b0;
    logic ihit, dhit, exmem_dreq, idex_memread, ifid_uses_rt, ifid_jump, exmem_branch, memwb_halt;
    logic [4:0] idex_rd, ifid_rs, ifid_rt;
    logic [7:0] out_d, out_l, out_c;
    logic [31:0] st_d, fl_d, st_l, fl_l;
    logic [3:0] st_c, fl_c;

    logic [7:0] sb[$];
    logic [7:0] e;
    int checks = 0, failures = 0;

    always #5 CLK = ~CLK;

    hazard_control u_def (.CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dreq(exmem_dreq),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_uses_rt(ifid_uses_rt), .ifid_jump(ifid_jump), .exmem_branch(exmem_branch),
        .memwb_halt(memwb_halt), .pc_en(out_d[7]), .ifid_en(out_d[6]), .ifid_flush(out_d[5]),
        .idex_en(out_d[4]), .idex_flush(out_d[3]), .exmem_en(out_d[2]), .memwb_en(out_d[1]),
        .halt(out_d[0]), .stall_cnt(st_d), .flush_cnt(fl_d));

    hazard_control #(.LOAD_USE_BUBBLES(3)) u_lu3 (.CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dreq(exmem_dreq), .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rs(ifid_rs),
        .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .ifid_jump(ifid_jump),
        .exmem_branch(exmem_branch), .memwb_halt(memwb_halt), .pc_en(out_l[7]), .ifid_en(out_l[6]),
        .ifid_flush(out_l[5]), .idex_en(out_l[4]), .idex_flush(out_l[3]), .exmem_en(out_l[2]),
        .memwb_en(out_l[1]), .halt(out_l[0]), .stall_cnt(st_l), .flush_cnt(fl_l));

    hazard_control #(.CNT_W(4)) u_c4 (.CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .exmem_dreq(exmem_dreq), .idex_memread(idex_memread), .idex_rd(idex_rd), .ifid_rs(ifid_rs),
        .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt), .ifid_jump(ifid_jump),
        .exmem_branch(exmem_branch), .memwb_halt(memwb_halt), .pc_en(out_c[7]), .ifid_en(out_c[6]),
        .ifid_flush(out_c[5]), .idex_en(out_c[4]), .idex_flush(out_c[3]), .exmem_en(out_c[2]),
        .memwb_en(out_c[1]), .halt(out_c[0]), .stall_cnt(st_c), .flush_cnt(fl_c));

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.ihit = 1'b1;
        return s;
    endfunction

    function automatic stim_t hazard_rs8();
        stim_t s;
        s = idle();
        s.idex_memread = 1'b1;
        s.idex_rd = 5'd8;
        s.ifid_rs = 5'd8;
        return s;
    endfunction

    // Wait for the falling edge, drive one cycle of inputs and queue the expected vector.
    task automatic apply(input stim_t s, input logic [7:0] exp_v);
        @(negedge CLK);
        {ihit, dhit, exmem_dreq, idex_memread, idex_rd, ifid_rs, ifid_rt,
         ifid_uses_rt, ifid_jump, exmem_branch, memwb_halt} = s;
        sb.push_back(exp_v);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        {ihit, dhit, exmem_dreq, idex_memread, idex_rd, ifid_rs, ifid_rt,
         ifid_uses_rt, ifid_jump, exmem_branch, memwb_halt} = idle();
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        stim_t s;
        @(negedge CLK);
        nRST = 1'b0;
        s = idle();
        s.exmem_branch = 1'b1;
        s.ifid_jump = 1'b1;
        apply(s, V_FREEZE);
        e = sb.pop_front();
        checks++;
        if (out_d !== e) begin failures++; $display("FAIL reset_outs got=%b exp=%b", out_d, e); end
        checks++;
        if (st_d !== 32'd0 || fl_d !== 32'd0) begin
            failures++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", st_d, fl_d);
        end
        @(negedge CLK);
        {ihit, dhit, exmem_dreq, idex_memread, idex_rd, ifid_rs, ifid_rt,
         ifid_uses_rt, ifid_jump, exmem_branch, memwb_halt} = idle();
        nRST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply(idle(), V_RUN);
            e = sb.pop_front();
            checks++;
            if (out_d !== e) begin failures++; $display("FAIL run_idle[%0d] got=%b exp=%b", i, out_d, e); end
        end
        checks++;
        if (st_d !== 32'd0 || fl_d !== 32'd0) begin
            failures++; $display("FAIL idle_cnts got=%0d/%0d exp=0/0", st_d, fl_d);
        end
    endtask

    task automatic test_load_use();
        stim_t s[6];
        logic [7:0] ev[6];
        do_reset();
        s[0] = hazard_rs8();                                  ev[0] = V_LU;
        s[1] = idle();                                        ev[1] = V_RUN;
        s[2] = idle(); s[2].idex_memread = 1'b1; s[2].idex_rd = 5'd9; s[2].ifid_rt = 5'd9;
                                                              ev[2] = V_RUN;
        s[3] = s[2];   s[3].ifid_uses_rt = 1'b1;              ev[3] = V_LU;
        s[4] = idle(); s[4].idex_memread = 1'b1;              ev[4] = V_RUN; // rd=0 is never a hazard
        s[5] = hazard_rs8(); s[5].exmem_branch = 1'b1;        ev[5] = V_BR;  // branch beats load-use
        for (int i = 0; i < 6; i++) begin
            apply(s[i], ev[i]);
            e = sb.pop_front();
            checks++;
            if (out_d !== e) begin failures++; $display("FAIL load_use[%0d] got=%b exp=%b", i, out_d, e); end
            if (i == 1) begin
                checks++;
                if (st_d !== 32'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", st_d); end
            end
        end
        apply(idle(), V_RUN);
        e = sb.pop_front();
        checks++;
        if (out_d !== e || st_d !== 32'd2 || fl_d !== 32'd1) begin
            failures++; $display("FAIL lu_end got=%b/%0d/%0d exp=%b/2/1", out_d, st_d, fl_d, e);
        end
    endtask

    task automatic test_lu3();
        stim_t br;
        do_reset();
        apply(hazard_rs8(), V_LU);
        for (int i = 0; i < 2; i++) apply(idle(), V_LU);   // LU_WAIT ignores cleared hazard
        apply(idle(), V_RUN);
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            // the four queued cycles are already past; recheck counts at the end
            if (i == 3) begin
                checks++;
                if (out_l !== e) begin failures++; $display("FAIL lu3_release got=%b exp=%b", out_l, e); end
            end
        end
        checks++;
        if (st_l !== 32'd3) begin failures++; $display("FAIL lu3_stall_cnt got=%0d exp=3", st_l); end
        br = idle(); br.exmem_branch = 1'b1;
        apply(hazard_rs8(), V_LU);
        e = sb.pop_front();
        checks++;
        if (out_l !== e) begin failures++; $display("FAIL lu3_bubble got=%b exp=%b", out_l, e); end
        apply(br, V_BR);
        e = sb.pop_front();
        checks++;
        if (out_l !== e) begin failures++; $display("FAIL lu3_branch_cancel got=%b exp=%b", out_l, e); end
        apply(idle(), V_RUN);
        e = sb.pop_front();
        checks++;
        if (out_l !== e) begin failures++; $display("FAIL lu3_after_cancel got=%b exp=%b", out_l, e); end
    endtask

    task automatic test_mem_stall_branch();
        stim_t s;
        do_reset();
        s = idle(); s.exmem_dreq = 1'b1; s.exmem_branch = 1'b1;
        for (int i = 0; i < 4; i++) begin
            apply(s, V_FREEZE);
            e = sb.pop_front();
            checks++;
            if (out_d !== e) begin failures++; $display("FAIL mem_freeze[%0d] got=%b exp=%b", i, out_d, e); end
        end
        s.dhit = 1'b1;
        apply(s, V_BR);
        e = sb.pop_front();
        checks++;
        if (out_d !== e) begin failures++; $display("FAIL stalled_branch got=%b exp=%b", out_d, e); end
        apply(idle(), V_RUN);
        e = sb.pop_front();
        checks++;
        if (out_d !== e || fl_d !== 32'd1 || st_d !== 32'd4) begin
            failures++; $display("FAIL mem_branch_end got=%b/st%0d/fl%0d exp=%b/st4/fl1", out_d, st_d, fl_d, e);
        end
    endtask

    task automatic test_jump();
        stim_t s;
        do_reset();
        s = idle(); s.ifid_jump = 1'b1;
        apply(s, V_JUMP);
        e = sb.pop_front();
        checks++;
        if (out_d !== e) begin failures++; $display("FAIL jump_hit got=%b exp=%b", out_d, e); end
        s.ihit = 1'b0;
        apply(s, V_IMISS);
        e = sb.pop_front();
        checks++;
        if (out_d !== e) begin failures++; $display("FAIL jump_miss got=%b exp=%b", out_d, e); end
        s = idle(); s.ihit = 1'b0;
        apply(s, V_IMISS);
        e = sb.pop_front();
        checks++;
        if (out_d !== e) begin failures++; $display("FAIL imiss got=%b exp=%b", out_d, e); end
        apply(idle(), V_RUN);
        e = sb.pop_front();
        checks++;
        if (out_d !== e || fl_d !== 32'd2 || st_d !== 32'd2) begin
            failures++; $display("FAIL jump_end got=%b/st%0d/fl%0d exp=%b/st2/fl2", out_d, st_d, fl_d, e);
        end
    endtask

    task automatic test_halt();
        stim_t s;
        do_reset();
        apply(hazard_rs8(), V_LU);
        void'(sb.pop_front());
        s = idle(); s.memwb_halt = 1'b1;
        apply(s, V_FREEZE);
        e = sb.pop_front();
        checks++;
        if (out_l !== e) begin failures++; $display("FAIL halt_entry got=%b exp=%b", out_l, e); end
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.exmem_branch = i[0]; s.ifid_jump = ~i[0]; s.ihit = i[1];
            apply(s, V_HALTED);
            e = sb.pop_front();
            checks++;
            if (out_l !== e) begin failures++; $display("FAIL halted[%0d] got=%b exp=%b", i, out_l, e); end
        end
        checks++;
        if (st_l !== 32'd2 || fl_l !== 32'd0) begin
            failures++; $display("FAIL halted_cnts got=%0d/%0d exp=2/0", st_l, fl_l);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (out_l !== V_FREEZE || st_l !== 32'd0 || fl_l !== 32'd0) begin
            failures++; $display("FAIL halt_reset got=%b/%0d/%0d exp=%b/0/0", out_l, st_l, fl_l, V_FREEZE);
        end
        @(negedge CLK);
        nRST = 1'b1;
        apply(idle(), V_RUN);
        e = sb.pop_front();
        checks++;
        if (out_l !== e) begin failures++; $display("FAIL after_halt_reset got=%b exp=%b", out_l, e); end
    endtask

    task automatic test_saturate();
        stim_t s;
        do_reset();
        s = idle(); s.ihit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            apply(s, V_IMISS);
            e = sb.pop_front();
            if (i == 16 || i == 19) begin
                checks++;
                if (out_c !== e || st_c !== 4'd15) begin
                    failures++; $display("FAIL sat[%0d] got=%b/%0d exp=%b/15", i, out_c, st_c, e);
                end
            end
        end
        checks++;
        if (fl_c !== 4'd0) begin failures++; $display("FAIL sat_flush got=%0d exp=0", fl_c); end
    endtask

    initial begin
        {ihit, dhit, exmem_dreq, idex_memread, idex_rd, ifid_rs, ifid_rt,
         ifid_uses_rt, ifid_jump, exmem_branch, memwb_halt} = idle();
        test_reset();
        test_load_use();
        test_lu3();
        test_mem_stall_branch();
        test_jump();
        test_halt();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
